// File: rtl/seq_shift_add_mul.sv
// ============================================================================
// seq_shift_add_mul : sequential unsigned shift-add multiplier, WIDTH x WIDTH
// Revision: 1.0
// ============================================================================
`default_nettype none

module seq_shift_add_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   Q,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] qr_q, qr_d;
  logic [WIDTH-1:0] br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Top bit of the sum is the E carry; it is shifted straight into A, so it
  // never needs to persist across cycles.
  logic [WIDTH:0]   sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      qr_q    <= '0;
      br_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      qr_q    <= qr_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    qr_d    = qr_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    sum     = qr_q[0] ? ({1'b0, a_q} + {1'b0, br_q}) : {1'b0, a_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          br_d    = B;
          qr_d    = Q;
          a_d     = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        a_d   = sum[WIDTH:1];
        qr_d  = {sum[0], qr_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign product = {a_q, qr_q};
  assign busy    = (state_q == CALC);
  assign done    = (state_q == DONE);

endmodule

`default_nettype wire

// File: tb/tb_seq_shift_add_mul.sv
// Self-checking bench for seq_shift_add_mul (WIDTH=8) against a plain a*b model.
`default_nettype none

module tb_seq_shift_add_mul;

  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   Q;
  logic [W-1:0]   B;
  logic [2*W-1:0] product;
  logic           busy;
  logic           done;

  int checks;
  int failures;

  seq_shift_add_mul #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .Q      (Q),
    .B      (B),
    .product(product),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned p;
    p = int'(a) * int'(b);
    return p[2*W-1:0];
  endfunction

  // Issue one transaction from IDLE; lat counts edges from the sampling edge
  // (inclusive) until done is seen. Returns with the DUT back in IDLE.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [2*W-1:0] prod, output int lat,
                       output int busy_n, output bit timeout);
    Q = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    lat     = 1;
    busy_n  = 0;
    timeout = 1'b1;
    prod    = '0;
    for (int i = 0; i < 30; i++) begin
      if (done === 1'b1) begin
        timeout = 1'b0;
        prod    = product;
        break;
      end
      if (busy === 1'b1) busy_n++;
      @(posedge clk); #1;
      lat++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; Q = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (product !== 16'h0000) begin failures++; $display("FAIL reset_product got=%h exp=0000", product); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [2*W-1:0] p; int lat; int bn; bit to;
    do_op(8'd13, 8'd11, p, lat, bn, to);
    checks++; if (to || p !== 16'h008F) begin failures++; $display("FAIL basic_product got=%h exp=008F timeout=%0d", p, to); end
    checks++; if (lat != 9) begin failures++; $display("FAIL basic_latency got=%0d exp=9", lat); end
    checks++; if (bn != 8) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=8", bn); end
  endtask

  task automatic test_corners();
    logic [W-1:0]   ta [4] = '{8'd255, 8'd0,   8'd1,   8'd200};
    logic [W-1:0]   tb [4] = '{8'd255, 8'd200, 8'd200, 8'd1};
    logic [2*W-1:0] te [4] = '{16'hFE01, 16'h0000, 16'h00C8, 16'h00C8};
    logic [2*W-1:0] p; int lat; int bn; bit to;
    for (int i = 0; i < 4; i++) begin
      do_op(ta[i], tb[i], p, lat, bn, to);
      checks++;
      if (to || p !== te[i] || lat != 9) begin
        failures++;
        $display("FAIL corner_%0d got=%h exp=%h lat=%0d timeout=%0d", i, p, te[i], lat, to);
      end
    end
  endtask

  task automatic test_busy_protect();
    int ndone = 0; int busy_after = 0;
    logic [2*W-1:0] p = '0;
    Q = 8'd6; B = 8'd7; start = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 30; c++) begin
      if (done === 1'b1) begin
        ndone++; p = product;
        start = 1'b1;
      end else if (c == 0) begin
        Q = 8'd9; B = 8'd9; start = 1'b0;
      end else if (busy === 1'b1) begin
        if (ndone > 0) busy_after++;
        start = c[0];
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    checks++; if (ndone != 1) begin failures++; $display("FAIL protect_done_count got=%0d exp=1", ndone); end
    checks++; if (p !== 16'h002A) begin failures++; $display("FAIL protect_product got=%h exp=002A", p); end
    checks++; if (busy_after != 0) begin failures++; $display("FAIL protect_no_restart busy_cycles=%0d exp=0", busy_after); end
    checks++; if (product !== 16'h002A) begin failures++; $display("FAIL protect_hold got=%h exp=002A", product); end
  endtask

  task automatic test_reset_mid();
    int ndone = 0;
    logic [2*W-1:0] p; int lat; int bn; bit to;
    Q = 8'd100; B = 8'd100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (product !== 16'h0000) begin failures++; $display("FAIL midrst_product got=%h exp=0000", product); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL midrst_flags busy=%b done=%b exp=0,0", busy, done); end
    for (int c = 0; c < 15; c++) begin
      if (done === 1'b1 || busy === 1'b1) ndone++;
      @(posedge clk); #1;
    end
    checks++; if (ndone != 0) begin failures++; $display("FAIL midrst_no_activity got=%0d exp=0", ndone); end
    do_op(8'd3, 8'd5, p, lat, bn, to);
    checks++; if (to || p !== 16'h000F) begin failures++; $display("FAIL midrst_after got=%h exp=000F", p); end
  endtask

  task automatic test_back_to_back();
    int nd = 0; int t1 = 0; int t2 = 0;
    logic [2*W-1:0] p1 = '0; logic [2*W-1:0] p2 = '0;
    Q = 8'hA5; B = 8'h5A; start = 1'b1;
    @(posedge clk); #1;
    Q = 8'h80; B = 8'h02;
    for (int c = 1; c < 40 && nd < 2; c++) begin
      if (done === 1'b1) begin
        nd++;
        if (nd == 1) begin p1 = product; t1 = c; end
        else begin p2 = product; t2 = c; start = 1'b0; end
      end
      if (nd < 2) begin
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
    checks++; if (nd != 2) begin failures++; $display("FAIL b2b_done_count got=%0d exp=2", nd); end
    checks++; if (p1 !== 16'h3A02) begin failures++; $display("FAIL b2b_product1 got=%h exp=3A02", p1); end
    checks++; if (p2 !== 16'h0100) begin failures++; $display("FAIL b2b_product2 got=%h exp=0100", p2); end
    checks++; if (t2 - t1 != 10) begin failures++; $display("FAIL b2b_spacing got=%0d exp=10", t2 - t1); end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [W-1:0] a; logic [W-1:0] b;
    logic [2*W-1:0] p; int lat; int bn; bit to;
    for (int i = 0; i < 1000; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      if (i < 8) a = (i[0]) ? 8'hFF : a;
      do_op(a, b, p, lat, bn, to);
      checks++;
      if (to || p !== ref_mul(a, b) || lat != 9 || bn != 8) begin
        failures++;
        $display("FAIL random_%0d a=%h b=%h got=%h exp=%h lat=%0d busy=%0d", i, a, b, p, ref_mul(a, b), lat, bn);
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; start = 1'b0; Q = '0; B = '0;
    test_reset();
    test_basic();
    test_corners();
    test_busy_protect();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
